// File: rtl/ni_pkg.sv
// ni_pkg: shared definitions for the MIPS network interface.
//   NI_DATA_W / NI_ADDR_W : default payload and node-address widths
//   FLIT_W                : default flit width, {dest, payload}
//   rx_state_t            : receive-side FSM encoding
package ni_pkg;

  localparam int NI_DATA_W = 32;
  localparam int NI_ADDR_W = 2;
  localparam int FLIT_W    = NI_ADDR_W + NI_DATA_W;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_WAIT    = 2'd1,
    RX_DELIVER = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: synchronous FIFO used for both the tx and rx queues.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   full/empty : status, decoded from the registered pointers
//   head       : oldest entry, stable until it is popped
module ni_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mips_network_interface.sv
// mips_network_interface: NoC-facing side of a MIPS core's send/receive path.
//   Core side : proc_valid_E/dest_add_E/NI_in (send pulse), proc_ready_in_E
//               (receive level), mips_ni/data_valid/wd_NI (delivery),
//               tx_full/tx_overflow (send status)
//   Router tx : ni_out_valid/ni_out_flit -> router_in_ready
//   Router rx : router_out_valid/router_out_flit -> ni_in_ready
//   Status    : misroute_cnt, saturating count of flits for other nodes
//
// Router handshakes are strict valid/ready: a flit moves on a rising edge
// where valid and ready are both high; valid never depends on ready, and
// the flit stays stable while valid is high and ready is low.
module mips_network_interface
  import ni_pkg::*;
#(
  parameter int DATA_W   = NI_DATA_W,
  parameter int ADDR_W   = NI_ADDR_W,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int NODE_ID  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_valid_E,
  input  logic [ADDR_W-1:0]        dest_add_E,
  input  logic [DATA_W-1:0]        NI_in,
  input  logic                     proc_ready_in_E,
  output logic                     mips_ni,
  output logic                     data_valid,
  output logic [DATA_W-1:0]        wd_NI,
  output logic                     tx_full,
  output logic                     tx_overflow,
  output logic                     ni_out_valid,
  output logic [ADDR_W+DATA_W-1:0] ni_out_flit,
  input  logic                     router_in_ready,
  input  logic                     router_out_valid,
  input  logic [ADDR_W+DATA_W-1:0] router_out_flit,
  output logic                     ni_in_ready,
  output logic [7:0]               misroute_cnt
);

  localparam int                FW      = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(NODE_ID);

  // ---------------- tx path ----------------
  logic          tx_empty;
  logic [FW-1:0] tx_head;
  logic          tx_pop;
  logic          tx_overflow_q, tx_overflow_d;

  assign tx_pop = ~tx_empty & router_in_ready;

  ni_fifo #(.WIDTH(FW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (proc_valid_E),
    .din   ({dest_add_E, NI_in}),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  assign ni_out_valid = ~tx_empty;
  assign ni_out_flit  = tx_head;
  assign tx_overflow  = tx_overflow_q;

  // A send while full is lost even if a pop frees a slot the same cycle.
  always_comb begin
    tx_overflow_d = tx_overflow_q | (proc_valid_E & tx_full);
  end

  // ---------------- rx path ----------------
  logic              rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic              rx_push, rx_pop;
  logic              rx_accept, dest_match;
  logic              rx_en_q, rx_en_d;
  logic [7:0]        misroute_cnt_q, misroute_cnt_d;

  // rx_en_q keeps ni_in_ready low during reset and for the first cycle after.
  assign ni_in_ready = rx_en_q & ~rx_full;
  assign dest_match  = (router_out_flit[FW-1 -: ADDR_W] == MY_ADDR);
  assign rx_accept   = router_out_valid & ni_in_ready;
  assign rx_push     = rx_accept & dest_match;

  ni_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (router_out_flit[DATA_W-1:0]),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  always_comb begin
    rx_en_d        = 1'b1;
    misroute_cnt_d = misroute_cnt_q;
    if (rx_accept && !dest_match && misroute_cnt_q != 8'hFF) begin
      misroute_cnt_d = misroute_cnt_q + 8'd1;
    end
  end

  assign misroute_cnt = misroute_cnt_q;

  // ---------------- rx FSM ----------------
  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] wd_ni_q, wd_ni_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RX_IDLE;
      wd_ni_q        <= '0;
      tx_overflow_q  <= 1'b0;
      rx_en_q        <= 1'b0;
      misroute_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wd_ni_q        <= wd_ni_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_en_q        <= rx_en_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  // Next-state logic. A receive the core abandons while waiting wins over
  // data arriving, so no flit is consumed for a receive nobody reads.
  always_comb begin
    state_d = state_q;
    wd_ni_d = wd_ni_q;
    unique case (state_q)
      RX_IDLE: begin
        if (proc_ready_in_E) state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (!proc_ready_in_E) begin
          state_d = RX_IDLE;
        end else if (!rx_empty) begin
          state_d = RX_DELIVER;
          wd_ni_d = rx_head;
        end
      end
      RX_DELIVER: state_d = RX_IDLE;
      default:    state_d = RX_IDLE;
    endcase
  end

  // Outputs decode the state register only, so they are glitch-free.
  always_comb begin
    mips_ni    = (state_q == RX_WAIT) || (state_q == RX_DELIVER);
    data_valid = (state_q == RX_DELIVER);
    rx_pop     = (state_q == RX_DELIVER);
  end

  assign wd_NI = wd_ni_q;

endmodule

// File: tb/tb_mips_network_interface.sv
module tb_mips_network_interface;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 2;
  localparam int FW      = ADDR_W + DATA_W;
  localparam int NODE_ID = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              proc_valid_E = 1'b0;
  logic [ADDR_W-1:0] dest_add_E = '0;
  logic [DATA_W-1:0] NI_in = '0;
  logic              proc_ready_in_E = 1'b0;
  logic              mips_ni, data_valid;
  logic [DATA_W-1:0] wd_NI;
  logic              tx_full, tx_overflow, ni_out_valid;
  logic [FW-1:0]     ni_out_flit;
  logic              router_in_ready = 1'b0;
  logic              router_out_valid = 1'b0;
  logic [FW-1:0]     router_out_flit = '0;
  logic              ni_in_ready;
  logic [7:0]        misroute_cnt;

  mips_network_interface #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TX_DEPTH(4), .RX_DEPTH(4), .NODE_ID(NODE_ID)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_valid_E(proc_valid_E), .dest_add_E(dest_add_E), .NI_in(NI_in),
    .proc_ready_in_E(proc_ready_in_E),
    .mips_ni(mips_ni), .data_valid(data_valid), .wd_NI(wd_NI),
    .tx_full(tx_full), .tx_overflow(tx_overflow),
    .ni_out_valid(ni_out_valid), .ni_out_flit(ni_out_flit),
    .router_in_ready(router_in_ready),
    .router_out_valid(router_out_valid), .router_out_flit(router_out_flit),
    .ni_in_ready(ni_in_ready), .misroute_cnt(misroute_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail = 0;

  logic [FW-1:0]     exp_q[$];     // flits the router should see, in order
  logic [DATA_W-1:0] rx_exp_q[$];  // payloads buffered for the core
  bit                m_ovf, m_rdy, m_mips, m_dv;
  int                m_mis;
  logic [DATA_W-1:0] m_wd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rx_exp_q.delete();
    m_ovf = 0; m_rdy = 0; m_mips = 0; m_dv = 0; m_mis = 0; m_wd = '0;
  endtask

  task automatic check_outputs();
    check_eq("ni_out_valid", 64'(ni_out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq("ni_out_flit", 64'(ni_out_flit), 64'(exp_q[0]));
    check_eq("tx_full", 64'(tx_full), 64'(exp_q.size() == 4));
    check_eq("tx_overflow", 64'(tx_overflow), 64'(m_ovf));
    check_eq("ni_in_ready", 64'(ni_in_ready), 64'(m_rdy && rx_exp_q.size() < 4));
    check_eq("misroute_cnt", 64'(misroute_cnt), 64'(m_mis));
    check_eq("mips_ni", 64'(mips_ni), 64'(m_mips));
    check_eq("data_valid", 64'(data_valid), 64'(m_dv));
    check_eq("wd_NI", 64'(wd_NI), 64'(m_wd));
  endtask

  // Advance the model over the next rising edge using the inputs currently
  // driven, then wait to the falling edge and compare every output.
  task automatic cycle();
    int                tx_before = exp_q.size();
    bit                rx_ready_now = m_rdy && (rx_exp_q.size() < 4);
    bit                rx_has_data = (rx_exp_q.size() != 0);
    logic [DATA_W-1:0] rx_front = rx_has_data ? rx_exp_q[0] : '0;
    bit                waiting = m_mips && !m_dv;
    bit                next_dv, next_mips;
    // tx: router takes the head when ready; a send needs a free slot before the edge
    if (tx_before != 0 && router_in_ready) void'(exp_q.pop_front());
    if (proc_valid_E) begin
      if (tx_before < 4) exp_q.push_back({dest_add_E, NI_in});
      else m_ovf = 1;
    end
    // rx: a delivery consumes one payload; incoming flits filtered by node id
    if (m_dv) void'(rx_exp_q.pop_front());
    if (router_out_valid && rx_ready_now) begin
      if (router_out_flit[FW-1 -: ADDR_W] == ADDR_W'(NODE_ID))
        rx_exp_q.push_back(router_out_flit[DATA_W-1:0]);
      else if (m_mis < 255) m_mis++;
    end
    // receive protocol: mips_ni follows the request by one cycle; data is
    // handed over one cycle after a waiting request sees buffered data.
    next_dv   = waiting && proc_ready_in_E && rx_has_data;
    next_mips = proc_ready_in_E && !m_dv;
    if (next_dv) m_wd = rx_front;
    m_dv   = next_dv;
    m_mips = next_mips;
    m_rdy  = 1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] p);
    proc_valid_E = 1'b1; dest_add_E = d; NI_in = p;
    cycle();
    proc_valid_E = 1'b0;
  endtask

  task automatic rx_flit(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] p);
    router_out_valid = 1'b1; router_out_flit = {d, p};
    cycle();
    router_out_valid = 1'b0;
  endtask

  task automatic receive_one(input logic [DATA_W-1:0] exp_payload);
    bit got = 0;
    proc_ready_in_E = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (data_valid) begin
        got = 1;
        check_eq("recv_payload", 64'(wd_NI), 64'(exp_payload));
      end
    end
    if (!got) check_eq("recv_timeout", 64'(0), 64'(1));
    proc_ready_in_E = 1'b0;
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle();
    check_eq("rst_ni_in_ready", 64'(ni_in_ready), 64'(1));

    // single send
    router_in_ready = 1'b1;
    send(2'd2, 32'hDEADBEEF);
    check_eq("send_valid", 64'(ni_out_valid), 64'(1));
    check_eq("send_flit", 64'(ni_out_flit), 64'({2'd2, 32'hDEADBEEF}));
    cycle();
    check_eq("send_valid_drop", 64'(ni_out_valid), 64'(0));

    // backpressure and overflow
    router_in_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(2'd1, DATA_W'(i));
      if (i == 4) check_eq("bp_full", 64'(tx_full), 64'(1));
    end
    check_eq("bp_overflow", 64'(tx_overflow), 64'(1));
    router_in_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("bp_order", 64'(ni_out_flit[DATA_W-1:0]), 64'(k));
      cycle();
    end
    check_eq("bp_drained", 64'(ni_out_valid), 64'(0));

    // receive with data already buffered
    rx_flit(ADDR_W'(NODE_ID), 32'h12345678);
    proc_ready_in_E = 1'b1;
    cycle();
    check_eq("rcv_mips_wait", 64'(mips_ni), 64'(1));
    check_eq("rcv_dv_early", 64'(data_valid), 64'(0));
    cycle();
    check_eq("rcv_dv", 64'(data_valid), 64'(1));
    check_eq("rcv_wd", 64'(wd_NI), 64'(32'h12345678));
    proc_ready_in_E = 1'b0;
    cycle();
    check_eq("rcv_dv_pulse", 64'(data_valid), 64'(0));
    check_eq("rcv_wd_hold", 64'(wd_NI), 64'(32'h12345678));

    // receive before data arrives
    proc_ready_in_E = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("wait_mips", 64'(mips_ni), 64'(1));
      check_eq("wait_no_dv", 64'(data_valid), 64'(0));
    end
    rx_flit(ADDR_W'(NODE_ID), 32'h000000A5);
    cycle();
    check_eq("late_dv", 64'(data_valid), 64'(1));
    check_eq("late_wd", 64'(wd_NI), 64'(32'hA5));
    proc_ready_in_E = 1'b0;
    cycle();

    // misroute and rx full
    rx_flit(2'd1, 32'h0BAD0001);
    check_eq("misroute_one", 64'(misroute_cnt), 64'(1));
    for (int i = 0; i < 4; i++) rx_flit(ADDR_W'(NODE_ID), 32'h100 + DATA_W'(i));
    check_eq("rx_full_ready", 64'(ni_in_ready), 64'(0));
    rx_flit(2'd3, 32'h0BAD0002);  // not accepted while full, so not counted
    check_eq("full_no_misroute", 64'(misroute_cnt), 64'(1));
    for (int i = 0; i < 4; i++) receive_one(32'h100 + DATA_W'(i));

    // misroute counter saturation
    for (int i = 0; i < 260; i++) rx_flit(2'd3, $urandom);
    check_eq("misroute_sat", 64'(misroute_cnt), 64'(255));

    // asynchronous reset with tx holding flits
    router_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd2, $urandom);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(ni_out_valid), 64'(0));
    check_eq("arst_overflow", 64'(tx_overflow), 64'(0));
    check_eq("arst_misroute", 64'(misroute_cnt), 64'(0));
    check_eq("arst_ni_in_ready", 64'(ni_in_ready), 64'(0));
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      proc_valid_E     = ($urandom_range(0, 9) < 4);
      dest_add_E       = ADDR_W'($urandom_range(0, 3));
      NI_in            = $urandom;
      router_in_ready  = ($urandom_range(0, 3) != 0);
      router_out_valid = ($urandom_range(0, 1) != 0);
      router_out_flit  = {($urandom_range(0, 3) != 0) ? ADDR_W'(NODE_ID)
                                                     : ADDR_W'($urandom_range(1, 3)),
                          DATA_W'($urandom)};
      if (m_dv) proc_ready_in_E = 1'b0;
      else if (!proc_ready_in_E && $urandom_range(0, 2) == 0) proc_ready_in_E = 1'b1;
      cycle();
    end

    // drain
    proc_valid_E = 1'b0;
    router_out_valid = 1'b0;
    router_in_ready = 1'b1;
    if (m_dv) proc_ready_in_E = 1'b0;
    cycle();
    proc_ready_in_E = 1'b0;
    repeat (6) cycle();
    check_eq("final_tx_empty", 64'(ni_out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
